fpdiv_ctrl: RTL and testbench

Sequencing FSM for the Goldschmidt floating-point divider datapath (fpdiv).
- Drives the mux selects (sel_mux3, sel_mux4) and register enables (en_a, en_b, en_rem) through the initial-approximation multiply, the refinement iterations and the remainder step.
- Replaces hand-timed testbench stimulus with a start/busy/done handshake.
- Sits beside fpdiv inside the divider top; upstream logic pulses start when operands are stable.

---
 rtl/fpdiv_pkg.sv | 27 ++
 rtl/fpdiv_ctrl.sv | 154 +++++++++++++++
 tb/tb_fpdiv_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and select encodings for the Goldschmidt divider control path.
// No logic, no latency, no backpressure; definitions only.
// Imported by fpdiv_ctrl.
package fpdiv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT_A = 3'd1,
        INIT_B = 3'd2,
        ITER_A = 3'd3,
        ITER_B = 3'd4,
        REM    = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [1:0] MUX3_IA  = 2'b00;
    localparam logic [1:0] MUX3_C   = 2'b01;
    localparam logic [1:0] MUX3_REM = 2'b10;

    localparam logic [1:0] MUX4_NUM = 2'b00;
    localparam logic [1:0] MUX4_DEN = 2'b01;
    localparam logic [1:0] MUX4_A   = 2'b10;
    localparam logic [1:0] MUX4_B   = 2'b11;

    localparam int NUM_ITER_DEFAULT = 6;

endpackage

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divider sequencer: drives mux selects and register loads for IA, refinement and remainder steps.
// Latency: start at edge k -> INIT_A in cycle k+1, done in cycle k+2*NUM_ITER+2; start while busy is dropped.
// Backpressure: optional stall input (FPDIV_CTRL_STALL_EN) freezes the sequence and masks register loads.
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter int NUM_ITER = NUM_ITER_DEFAULT,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef FPDIV_CTRL_STALL_EN
    input  logic              stall,
`endif
    output logic              busy,
    output logic              done,
    output logic [1:0]        sel_mux3,
    output logic [1:0]        sel_mux4,
    output logic              en_a,
    output logic              en_b,
    output logic              en_rem,
    output logic [ITER_W-1:0] iter
);

    localparam logic [ITER_W-1:0] LP_ONE  = ITER_W'(1);
    localparam logic [ITER_W-1:0] LP_LAST = ITER_W'(NUM_ITER);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ITER_W-1:0] r_iter;
    logic [ITER_W-1:0] w_iter_nxt;
    logic              w_hold;

`ifdef FPDIV_CTRL_STALL_EN
    assign w_hold = stall;
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_iter  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_iter  <= w_iter_nxt;
        end
    end

    // IDLE and DONE ignore w_hold: a stall only freezes an operation in flight.
    always_comb begin
        w_state_nxt = r_state;
        w_iter_nxt  = r_iter;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = INIT_A;
                    w_iter_nxt  = LP_ONE;
                end
            end
            INIT_A: begin
                if (!w_hold) w_state_nxt = INIT_B;
            end
            INIT_B: begin
                if (!w_hold) begin
                    if (NUM_ITER == 1) begin
                        w_state_nxt = REM;
                    end else begin
                        w_state_nxt = ITER_A;
                        w_iter_nxt  = r_iter + LP_ONE;
                    end
                end
            end
            ITER_A: begin
                if (!w_hold) w_state_nxt = ITER_B;
            end
            ITER_B: begin
                if (!w_hold) begin
                    if (r_iter == LP_LAST) begin
                        w_state_nxt = REM;
                    end else begin
                        w_state_nxt = ITER_A;
                        w_iter_nxt  = r_iter + LP_ONE;
                    end
                end
            end
            REM: begin
                if (!w_hold) begin
                    w_state_nxt = DONE;
                    w_iter_nxt  = '0;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = INIT_A;
                    w_iter_nxt  = LP_ONE;
                end else begin
                    w_state_nxt = IDLE;
                    w_iter_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_iter_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        sel_mux3 = MUX3_IA;
        sel_mux4 = MUX4_NUM;
        en_a     = 1'b0;
        en_b     = 1'b0;
        en_rem   = 1'b0;
        iter     = r_iter;
        case (r_state)
            INIT_A: begin
                busy = 1'b1;
                en_a = !w_hold;
            end
            INIT_B: begin
                busy     = 1'b1;
                sel_mux4 = MUX4_DEN;
                en_b     = !w_hold;
            end
            ITER_A: begin
                busy     = 1'b1;
                sel_mux4 = MUX4_A;
                sel_mux3 = MUX3_C;
                en_a     = !w_hold;
            end
            ITER_B: begin
                busy     = 1'b1;
                sel_mux4 = MUX4_B;
                sel_mux3 = MUX3_C;
                en_b     = !w_hold;
            end
            REM: begin
                busy     = 1'b1;
                sel_mux4 = MUX4_A;
                sel_mux3 = MUX3_REM;
                en_rem   = !w_hold;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Scoreboarded bench for fpdiv_ctrl: accepted starts push the full expected output trace; a negedge monitor pops and compares.
module tb_fpdiv_ctrl;

    localparam int N = 6;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stall;
    logic       busy, done, en_a, en_b, en_rem;
    logic [1:0] sel_mux3, sel_mux4;
    logic [3:0] iter;

    int checks = 0;
    int errors = 0;

    // {busy, done, sel_mux4, sel_mux3, en_a, en_b, en_rem, iter}
    logic [12:0] exp_q[$];

    fpdiv_ctrl #(.NUM_ITER(N), .ITER_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef FPDIV_CTRL_STALL_EN
        .stall    (stall),
`endif
        .busy     (busy),
        .done     (done),
        .sel_mux3 (sel_mux3),
        .sel_mux4 (sel_mux4),
        .en_a     (en_a),
        .en_b     (en_b),
        .en_rem   (en_rem),
        .iter     (iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input logic b, input logic d, input logic [1:0] s4,
                                       input logic [1:0] s3, input logic [2:0] en, input int it);
        logic [3:0] itv;
        itv = it[3:0];
        return {b, d, s4, s3, en, itv};
    endfunction

    // One whole division as the sequence of cycles it must produce.
    task automatic push_division();
        exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 2'd0, 3'b100, 1));
        exp_q.push_back(mk(1'b1, 1'b0, 2'd1, 2'd0, 3'b010, 1));
        for (int i = 2; i <= N; i++) begin
            exp_q.push_back(mk(1'b1, 1'b0, 2'd2, 2'd1, 3'b100, i));
            exp_q.push_back(mk(1'b1, 1'b0, 2'd3, 2'd1, 3'b010, i));
        end
        exp_q.push_back(mk(1'b1, 1'b0, 2'd2, 2'd2, 3'b001, N));
        exp_q.push_back(mk(1'b0, 1'b1, 2'd0, 2'd0, 3'b000, 0));
    endtask

    // Reference model: a division is accepted only when nothing is in flight.
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            exp_q.delete();
        end else if (start === 1'b1 && exp_q.size() == 0) begin
            push_division();
        end
    end

    initial begin : monitor
        logic [12:0] act, exp;
        logic        stalled;
        @(posedge clk);
        forever begin
            @(negedge clk);
            act = {busy, done, sel_mux4, sel_mux3, en_a, en_b, en_rem, iter};
            if (exp_q.size() != 0) begin
                exp = exp_q[0];
                stalled = 1'b0;
`ifdef FPDIV_CTRL_STALL_EN
                stalled = stall && exp[12];
`endif
                if (stalled) exp[6:4] = 3'b000;
                else exp_q.pop_front();
            end else begin
                exp = '0;
            end
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL outvec t=%0t actual=%b required=%b", $time, act, exp);
            end
        end
    end

    task automatic cyc(input logic st, input logic rs, input logic sl);
        @(posedge clk);
        #1;
        start = st;
        reset = rs;
        stall = sl;
    endtask

    task automatic wait_for(input logic [1:0] s4, input int it, input string name);
        int n;
        n = 0;
        while (!(busy === 1'b1 && sel_mux4 === s4 && iter === it[3:0]) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL %s_timeout actual=sel4 %b iter %0d required=sel4 %b iter %0d",
                     name, sel_mux4, iter, s4, it);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        stall = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        // Single division.
        cyc(1'b1, 1'b0, 1'b0);
        repeat (18) cyc(1'b0, 1'b0, 1'b0);

        // Start held high: back-to-back divisions with no IDLE between.
        repeat (30) cyc(1'b1, 1'b0, 1'b0);
        repeat (18) cyc(1'b0, 1'b0, 1'b0);

        // Start pulse during ITER_A with iter=3 must be dropped.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        wait_for(2'b10, 3, "iter3");
        start = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        repeat (16) cyc(1'b0, 1'b0, 1'b0);

        // Reset during ITER_B with iter=4, start held with it.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        wait_for(2'b11, 4, "iterb4");
        reset = 1'b1;
        start = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, 1'b0, 1'b0);

`ifdef FPDIV_CTRL_STALL_EN
        // Stall for three cycles in ITER_A with iter=2.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        wait_for(2'b10, 2, "stall_iter2");
        stall = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        stall = 1'b0;
        repeat (20) cyc(1'b0, 1'b0, 1'b0);
`endif

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0);
        end
        repeat (25) cyc(1'b0, 1'b0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
